// File: rtl/exhaustive_stim_checker.sv
// -----------------------------------------------------------------------------
// exhaustive_stim_checker
//
// On-board self-test engine for 3-input / 2-output combinational blocks.
// Walks the stimulus {a,b,c} through 000..111 in ascending order. Each
// pattern is held for DWELL cycles. The block under test's x,y are sampled
// on the last cycle of each hold and compared against the EXPECT_X /
// EXPECT_Y truth tables. Bit i of each table is the expected value for
// pattern i = {a,b,c}.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        level-sampled run request (honoured in IDLE and DONE)
//   a, b, c      stimulus bits 2, 1, 0
//   x, y         outputs of the block under test
//   busy         sweep in progress
//   done         sweep complete; held until the next accepted start
//   pass         valid with done; 1 when no pattern mismatched
//   err_count    number of mismatching patterns (0..8)
//   zero_hits    number of patterns sampled with x==0 and y==0 (0..8)
//   fail_valid   at least one mismatch recorded this sweep
//   fail_pattern first mismatching pattern; 0 while fail_valid==0
// -----------------------------------------------------------------------------
module exhaustive_stim_checker #(
    parameter int          DWELL    = 20,
    parameter logic [7:0]  EXPECT_X = 8'h00,
    parameter logic [7:0]  EXPECT_Y = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] zero_hits,
    output logic       fail_valid,
    output logic [2:0] fail_pattern
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Dwell counter value on the sampling edge of each pattern.
    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    state_t     state_r;
    logic [2:0] pattern_r;
    logic [7:0] cnt_r;
    logic [2:0] abc_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [3:0] err_count_r;
    logic [3:0] zero_hits_r;
    logic       fail_valid_r;
    logic [2:0] fail_pattern_r;

    logic       sample_s;
    logic       mismatch_s;
    logic       both_zero_s;
    logic [3:0] err_next_s;

    // Compare one sampled {x,y} pair against the truth tables.
    function automatic logic pattern_mismatch(input logic [2:0] pat,
                                              input logic       xs,
                                              input logic       ys);
        return (xs != EXPECT_X[pat]) || (ys != EXPECT_Y[pat]);
    endfunction

    // Decode the end-of-dwell sample and the error count it will produce.
    always_comb begin
        sample_s    = 1'b0;
        mismatch_s  = pattern_mismatch(pattern_r, x, y);
        both_zero_s = ~x & ~y;
        err_next_s  = err_count_r;
        if ((state_r == ST_DRIVE) && (cnt_r == LAST_CNT)) begin
            sample_s = 1'b1;
            if (mismatch_s) begin
                err_next_s = err_count_r + 4'd1;
            end else begin
                err_next_s = err_count_r;
            end
        end else begin
            sample_s   = 1'b0;
            err_next_s = err_count_r;
        end
    end

    // Sweep sequencer: state, stimulus, dwell counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            pattern_r      <= 3'd0;
            cnt_r          <= 8'd0;
            abc_r          <= 3'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            err_count_r    <= 4'd0;
            zero_hits_r    <= 4'd0;
            fail_valid_r   <= 1'b0;
            fail_pattern_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // DONE holds its results until a new start is accepted.
                    if (start) begin
                        state_r        <= ST_DRIVE;
                        pattern_r      <= 3'd0;
                        cnt_r          <= 8'd0;
                        abc_r          <= 3'd0;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                        pass_r         <= 1'b0;
                        err_count_r    <= 4'd0;
                        zero_hits_r    <= 4'd0;
                        fail_valid_r   <= 1'b0;
                        fail_pattern_r <= 3'd0;
                    end else begin
                        abc_r  <= 3'd0;
                        busy_r <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (sample_s) begin
                        err_count_r <= err_next_s;
                        // Only the first mismatch of a sweep is latched.
                        if (mismatch_s && !fail_valid_r) begin
                            fail_valid_r   <= 1'b1;
                            fail_pattern_r <= pattern_r;
                        end else begin
                            fail_valid_r   <= fail_valid_r;
                        end
                        if (both_zero_s) begin
                            zero_hits_r <= zero_hits_r + 4'd1;
                        end else begin
                            zero_hits_r <= zero_hits_r;
                        end
                        cnt_r <= 8'd0;
                        if (pattern_r == 3'd7) begin
                            // pass must include the pattern-7 sample taken on this edge.
                            state_r <= ST_DONE;
                            abc_r   <= 3'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == 4'd0);
                        end else begin
                            pattern_r <= pattern_r + 3'd1;
                            abc_r     <= pattern_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    abc_r   <= 3'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign a            = abc_r[2];
    assign b            = abc_r[1];
    assign c            = abc_r[0];
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign err_count    = err_count_r;
    assign zero_hits    = zero_hits_r;
    assign fail_valid   = fail_valid_r;
    assign fail_pattern = fail_pattern_r;

endmodule

// File: tb/tb_exhaustive_stim_checker.sv
// -----------------------------------------------------------------------------
// Testbench for exhaustive_stim_checker.
// Two instances run on a shared clock:
//   dut0 : DWELL=20, default truth tables (all zero)
//   dut1 : DWELL=2,  EXPECT_X=8'hC0 (x=a&b), EXPECT_Y=8'hEE (y=b|c)
// The simulated block under test is a truth table (tt_x/tt_y) per instance,
// so stuck-at outputs, the a&b / b|c model and random functions are all just
// different tables. When a sweep is started the expected results are
// pushed into a queue. A negedge monitor checks the stimulus stepping and
// pops and compares the entry when done rises.
// -----------------------------------------------------------------------------
module tb_exhaustive_stim_checker;

    localparam int         D0  = 20;
    localparam int         D1  = 2;
    localparam logic [7:0] EX0 = 8'h00;
    localparam logic [7:0] EY0 = 8'h00;
    localparam logic [7:0] EX1 = 8'hC0;
    localparam logic [7:0] EY1 = 8'hEE;

    typedef struct {
        int         e0;
        logic [3:0] err;
        logic [3:0] zh;
        logic       fv;
        logic [2:0] fp;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]      rst_n_v;
    logic [1:0]      start_v;
    logic [1:0]      a_v, b_v, c_v, x_v, y_v;
    logic [1:0]      busy_v, done_v, pass_v, fv_v;
    logic [1:0][3:0] err_v, zh_v;
    logic [1:0][2:0] fp_v;
    logic [1:0][7:0] tt_x, tt_y;
    logic [1:0]      prev_done = 2'b00;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    assign x_v[0] = tt_x[0][{a_v[0], b_v[0], c_v[0]}];
    assign y_v[0] = tt_y[0][{a_v[0], b_v[0], c_v[0]}];
    assign x_v[1] = tt_x[1][{a_v[1], b_v[1], c_v[1]}];
    assign y_v[1] = tt_y[1][{a_v[1], b_v[1], c_v[1]}];

    exhaustive_stim_checker #(.DWELL(D0), .EXPECT_X(EX0), .EXPECT_Y(EY0)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .x(x_v[0]), .y(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .zero_hits(zh_v[0]),
        .fail_valid(fv_v[0]), .fail_pattern(fp_v[0])
    );

    exhaustive_stim_checker #(.DWELL(D1), .EXPECT_X(EX1), .EXPECT_Y(EY1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .x(x_v[1]), .y(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .zero_hits(zh_v[1]),
        .fail_valid(fv_v[1]), .fail_pattern(fp_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Reference: results of a whole sweep from the truth tables.
    function automatic exp_t model(input int i, input int e0);
        exp_t       r;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       mis;
        ex     = (i == 0) ? EX0 : EX1;
        ey     = (i == 0) ? EY0 : EY1;
        r.e0   = e0;
        r.err  = 4'd0;
        r.zh   = 4'd0;
        r.fv   = 1'b0;
        r.fp   = 3'd0;
        for (int p = 0; p < 8; p++) begin
            mis = (tt_x[i][p] != ex[p]) || (tt_y[i][p] != ey[p]);
            if (mis) begin
                r.err = r.err + 4'd1;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.fp = 3'(p);
                end
            end
            if (!tt_x[i][p] && !tt_y[i][p]) r.zh = r.zh + 4'd1;
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    task automatic push(input int i, input int e0);
        exp_t e;
        e = model(i, e0);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Pulse start for one edge; the sampling edge is the next posedge.
    task automatic start_sweep(input int i);
        start_v[i] = 1'b1;
        push(i, cyc + 1);
        step(1);
        start_v[i] = 1'b0;
    endtask

    task automatic run_sweep(input int i);
        start_sweep(i);
        step(8 * ((i == 0) ? D0 : D1) + 3);
    endtask

    task automatic chk_cleared(input string name, input int i);
        chk(name, 32'({busy_v[i], done_v[i], pass_v[i], fv_v[i], err_v[i], zh_v[i],
                       fp_v[i], a_v[i], b_v[i], c_v[i]}), 32'd0);
    endtask

    // Monitor: stepping checks during a sweep, result check when done rises.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t cur;
            int   t;
            int   d;
            bit   have;
            d    = (i == 0) ? D0 : D1;
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            t    = 0;
            if (have) begin
                cur = (i == 0) ? q0[0] : q1[0];
                t   = cyc - cur.e0;
            end
            if (done_v[i] && !prev_done[i]) begin
                if (have) begin
                    chk("done_time", 32'(t), 32'(8 * d));
                    chk("busy_at_done", 32'(busy_v[i]), 32'd0);
                    chk("abc_at_done", 32'({a_v[i], b_v[i], c_v[i]}), 32'd0);
                    chk("err_count", 32'(err_v[i]), 32'(cur.err));
                    chk("zero_hits", 32'(zh_v[i]), 32'(cur.zh));
                    chk("fail_valid", 32'(fv_v[i]), 32'(cur.fv));
                    chk("fail_pattern", 32'(fp_v[i]), 32'(cur.fp));
                    chk("pass", 32'(pass_v[i]), 32'(cur.pass));
                    if (i == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end else begin
                    chk("unexpected_done", 32'(done_v[i]), 32'd0);
                end
            end else if (have && t >= 0 && t < 8 * d) begin
                chk("busy_in_sweep", 32'(busy_v[i]), 32'd1);
                chk("done_in_sweep", 32'(done_v[i]), 32'd0);
                chk("abc_step", 32'({a_v[i], b_v[i], c_v[i]}), 32'(t / d));
            end else if (have && t >= 8 * d) begin
                chk("done_timeout", 32'(t), 32'(8 * d - 1));
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end else if (!have) begin
                chk("idle_busy", 32'(busy_v[i]), 32'd0);
                chk("idle_abc", 32'({a_v[i], b_v[i], c_v[i]}), 32'd0);
            end
            prev_done[i] <= done_v[i];
        end
    end

    initial begin
        rst_n_v = 2'b00;
        start_v = 2'b00;
        tt_x    = '0;
        tt_y    = '0;
        step(2);
        rst_n_v = 2'b11;
        step(1);
        chk_cleared("reset_state0", 0);
        chk_cleared("reset_state1", 1);

        // dut0: outputs tied low -> pass, 8 zero hits.
        tt_x[0] = 8'h00; tt_y[0] = 8'h00;
        run_sweep(0);
        // dut0: x stuck at 1 -> every pattern fails, first at 000.
        tt_x[0] = 8'hFF; tt_y[0] = 8'h00;
        run_sweep(0);
        // dut0: two mismatches, first at pattern 2.
        tt_x[0] = 8'h24; tt_y[0] = 8'h00;
        run_sweep(0);
        // dut0: random functions.
        for (int k = 0; k < 2; k++) begin
            tt_x[0] = 8'($urandom);
            tt_y[0] = 8'($urandom);
            run_sweep(0);
        end

        // dut0: reset while pattern 5 is driven aborts the sweep.
        tt_x[0] = 8'h00; tt_y[0] = 8'h00;
        start_sweep(0);
        step(5 * D0 + 3);
        chk("abc_before_reset", 32'({a_v[0], b_v[0], c_v[0]}), 32'd5);
        rst_n_v[0] = 1'b0;
        step(1);
        rst_n_v[0] = 1'b1;
        q0.delete();
        chk_cleared("reset_midsweep", 0);
        step(10);
        chk_cleared("no_restart_after_reset", 0);

        // dut0: start pulses during DRIVE are ignored.
        tt_x[0] = 8'h02; tt_y[0] = 8'h00;
        start_sweep(0);
        step(30);
        start_v[0] = 1'b1; step(1); start_v[0] = 1'b0;
        step(50);
        start_v[0] = 1'b1; step(1); start_v[0] = 1'b0;
        step(8 * D0);
        chk("done_held", 32'(done_v[0]), 32'd1);
        // dut0: start in DONE clears done and reruns.
        tt_x[0] = 8'h00;
        run_sweep(0);

        // dut1: x=a&b, y=b|c matches its tables.
        tt_x[1] = 8'hC0; tt_y[1] = 8'hEE;
        run_sweep(1);
        // dut1: y differs at pattern 000.
        tt_x[1] = 8'hC0; tt_y[1] = 8'hEF;
        run_sweep(1);
        // dut1: start held high -> back-to-back sweeps, DONE lasts one cycle.
        tt_x[1] = 8'hC0; tt_y[1] = 8'hEE;
        start_v[1] = 1'b1;
        push(1, cyc + 1);
        push(1, cyc + 1 + 8 * D1 + 1);
        step(20);
        start_v[1] = 1'b0;
        step(8 * D1 + 3);
        // dut1: random functions.
        for (int k = 0; k < 4; k++) begin
            tt_x[1] = 8'($urandom);
            tt_y[1] = 8'($urandom);
            run_sweep(1);
        end

        step(3);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exhaustive_stim_checker.md
Name: exhaustive_stim_checker

Overview:
- Synthesizable on-board self-test engine for the 3-input/2-output combinational lab blocks.
- Drives every input pattern a,b,c = 000..111 in ascending order and holds each pattern for DWELL cycles.
- Samples outputs x,y at the end of each hold and compares them against a parameterized truth table.
- Reports mismatch count, first failing pattern, both-zero hit count, and pass/done flags; replaces simulation-only stimulus with hardware usable on the board.

Parameters:
- DWELL, 20, cycles each pattern is held before sampling; legal range 2..255.
- EXPECT_X, 8'h00, expected x truth table; bit i = expected x for pattern i, where i = {a,b,c}.
- EXPECT_Y, 8'h00, expected y truth table; same indexing as EXPECT_X.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level-sampled run request.
- a  out  1  stimulus MSB (pattern bit 2).
- b  out  1  stimulus bit 1.
- c  out  1  stimulus LSB (pattern bit 0).
- x  in  1  DUT output x.
- y  in  1  DUT output y.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high once a sweep completes; held until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  4  number of patterns whose {x,y} differed from expected (0..8).
- zero_hits  out  4  number of patterns sampled with x==0 and y==0 (0..8).
- fail_valid  out  1  at least one mismatch has been recorded this sweep.
- fail_pattern  out  3  {a,b,c} of the first mismatching pattern; 0 when fail_valid=0.

Behaviour:
- Reset:
  - Applied on a clk edge with rst_n=0; asynchronous rst_n has no effect.
  - All outputs go to 0; state IDLE; dwell counter 0.
  - Reset mid-sweep aborts immediately; no partial results survive.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - {a,b,c}=000, busy=0.
  - start=1 at an edge: clear err_count, zero_hits, fail_valid, fail_pattern, done, pass; pattern=0; cnt=0; go to DRIVE.
- DRIVE:
  - busy=1; {a,b,c}=pattern; cnt increments each edge.
  - At the edge where cnt==DWELL-1, sample x,y:
    - mismatch if x!=EXPECT_X[pattern] or y!=EXPECT_Y[pattern] → err_count+1.
    - If fail_valid=0 on that mismatch, latch fail_pattern=pattern and set fail_valid=1.
    - x==0 && y==0 → zero_hits+1.
    - If pattern==7 go to DONE; else pattern+1, cnt=0.
- DRIVE ignores start.
- DONE:
  - busy=0, done=1, pass=(err_count==0) using the final count, including the pattern-7 sample.
  - {a,b,c} returns to 000.
  - start=1 at an edge restarts exactly as from IDLE; done and pass drop on that edge.
- Timing: with start sampled at edge E0:
  - Pattern p is driven from E0+p*DWELL.
  - Pattern p is sampled at edge E0+(p+1)*DWELL.
  - done is high after edge E0+8*DWELL; a full sweep takes 8*DWELL cycles.
- Counters never exceed 8, so no saturation logic is needed; the 4-bit width is exact.
- Sampling is registered only; x,y are treated as stable for at least DWELL-1 cycles after a pattern change.
- If start is held high continuously, sweeps repeat back-to-back: DONE lasts one cycle, then the engine restarts.

Test Plan:
- DUT tied x=0,y=0, defaults, DWELL=20; start pulse at E0 → busy 1..160 cycles; done=1, pass=1, err_count=0, zero_hits=8, fail_valid=0 at E0+160.
- Model x=a&b, y=b|c with EXPECT_X=8'hC0, EXPECT_Y=8'hEE → pass=1, err_count=0, zero_hits=2 (patterns 000 and 100).
- Same model with EXPECT_Y=8'hEF → err_count=1, fail_valid=1, fail_pattern=3'b000, pass=0.
- x stuck at 1, defaults → err_count=8, fail_pattern=000, zero_hits=0; check a,b,c step 000→111 every DWELL cycles.
- rst_n=0 for one edge while pattern=5 → all outputs 0, state IDLE, {a,b,c}=000; no restart until the next start.
- start pulses during DRIVE are ignored (sweep completes at E0+8*DWELL); start in DONE clears done and reruns; DWELL=2 gives done at E0+16.
